// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1-to-N demultiplexer: FSM state
// encoding and default geometry.
package demux_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int SW_DEF    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/demux1to16_reg_decoder4to16.sv
// Index to one-hot write mask; all zeros when en is low.
module decoder4to16 #(
  parameter int WIDTH = demux_pkg::WIDTH_DEF,
  parameter int SW    = demux_pkg::SW_DEF
) (
  input  logic             en,
  input  logic [SW-1:0]    index,
  output logic [WIDTH-1:0] mask
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_line
    assign mask[i] = en && (index == SW'(i));
  end
endmodule

// File: rtl/demux1to16_reg.sv
// Registered 1-to-WIDTH demux with a direct-write mode (sel) and an
// auto-fill frame mode that walks idx from 0 to WIDTH-1.
module demux1to16_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SW    = SW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic [SW-1:0]    sel,
  input  logic             wr_en,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic [SW-1:0]    idx
);
  state_t           state;
  logic [SW-1:0]    wr_idx;
  logic             wr_ok;
  logic [WIDTH-1:0] mask;

  // start wins over a same-cycle direct write; DONE swallows writes
  assign wr_ok  = wr_en && ((state == IDLE && !start) || state == FILL);
  assign wr_idx = (state == FILL) ? idx : sel;

  decoder4to16 #(.WIDTH(WIDTH), .SW(SW)) u_dec (
    .en    (wr_ok),
    .index (wr_idx),
    .mask  (mask)
  );

  assign busy = (state == FILL);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      out   <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= FILL;
            out   <= '0;
            idx   <= '0;
          end else begin
            out <= (out & ~mask) | ({WIDTH{in}} & mask);
          end
        end
        FILL: begin
          out <= (out & ~mask) | ({WIDTH{in}} & mask);
          if (wr_en) begin
            idx <= idx + SW'(1);
            if (idx == SW'(WIDTH - 1)) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_demux1to16_reg.sv
// Bench for demux1to16_reg: constant-checked vector tables, hand sequences
// for stall/collision/reset corners, and random traffic against a frame model.
module tb_demux1to16_reg;
  logic        clk = 1'b0;
  logic        rst, in, wr_en, start;
  logic [3:0]  sel;
  logic [15:0] out;
  logic        busy, done;
  logic [3:0]  idx;

  demux1to16_reg #(.WIDTH(16), .SW(4)) dut (
    .clk(clk), .rst(rst), .in(in), .sel(sel), .wr_en(wr_en),
    .start(start), .out(out), .busy(busy), .done(done), .idx(idx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: m_pos = -1 idle, 0..15 bits written so far in a frame, 16 = done cycle
  bit [15:0] m_out;
  int        m_pos;

  typedef struct {
    bit        s, w, d;
    bit [3:0]  sl;
    bit [15:0] eo;
    bit        eb, ed;
    bit [3:0]  ei;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_out = '0;
    m_pos = -1;
  endfunction

  function automatic void model_step(bit s, bit w, bit d, bit [3:0] sl);
    if (m_pos == 16) m_pos = -1;
    else if (m_pos < 0) begin
      if (s) begin m_pos = 0; m_out = '0; end
      else if (w) m_out[sl] = d;
    end else if (w) begin
      m_out[m_pos] = d;
      m_pos++;
    end
  endfunction

  task automatic chk_model(input string tag);
    bit f;
    f = (m_pos >= 0 && m_pos < 16);
    chk({tag, ".out"},  out,  m_out);
    chk({tag, ".busy"}, busy, f);
    chk({tag, ".done"}, done, m_pos == 16);
    chk({tag, ".idx"},  idx,  f ? m_pos : 0);
  endtask

  // One clock with given inputs; inputs change #1 after an edge
  task automatic cyc(input bit s, input bit w, input bit d, input bit [3:0] sl, input string tag);
    start = s; wr_en = w; in = d; sel = sl;
    @(posedge clk); #1;
    model_step(s, w, d, sl);
    chk_model(tag);
    start = 0; wr_en = 0;
  endtask

  task automatic chk_rst_state(input string tag);
    chk({tag, ".out"},  out,  16'h0000);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".done"}, done, 1'b0);
    chk({tag, ".idx"},  idx,  4'h0);
  endtask

  localparam bit [15:0] PAT = 16'h3f0a;

  initial begin
    vec_t v;
    bit [15:0] pat;
    logic [3:0] dsel [9];
    logic [15:0] dexp [9];
    bit saw_done;

    pat = PAT;
    dsel = '{4'h1, 4'h3, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'h3};
    dexp = '{16'h0002, 16'h000a, 16'h010a, 16'h030a, 16'h070a,
             16'h0f0a, 16'h1f0a, 16'h3f0a, 16'h3f02};
    for (int i = 0; i < 9; i++) begin
      v = '{s:0, w:1, d:(i != 8), sl:dsel[i], eo:dexp[i], eb:0, ed:0, ei:0};
      tbl.push_back(v);
    end
    // Auto-fill frame of PAT, LSB first
    v = '{s:1, w:1, d:1, sl:4'h2, eo:16'h0000, eb:1, ed:0, ei:0};
    tbl.push_back(v);
    for (int k = 0; k < 16; k++) begin
      v = '{s:0, w:1, d:pat[k], sl:4'hF, eo:pat & 16'((32'd1 << (k + 1)) - 1),
            eb:(k < 15), ed:(k == 15), ei:4'((k + 1) % 16)};
      tbl.push_back(v);
    end
    // DONE cycle ignores start and wr_en
    v = '{s:1, w:1, d:0, sl:4'h3, eo:PAT, eb:0, ed:0, ei:0};
    tbl.push_back(v);

    rst = 1; in = 0; wr_en = 0; start = 0; sel = '0;
    model_reset();
    #7;
    chk_rst_state("por");
    @(posedge clk); #1;
    rst = 0;

    foreach (tbl[i]) begin
      cyc(tbl[i].s, tbl[i].w, tbl[i].d, tbl[i].sl, "tbl_model");
      chk($sformatf("tbl%0d.out", i),  out,  tbl[i].eo);
      chk($sformatf("tbl%0d.busy", i), busy, tbl[i].eb);
      chk($sformatf("tbl%0d.done", i), done, tbl[i].ed);
      chk($sformatf("tbl%0d.idx", i),  idx,  tbl[i].ei);
    end

    // Asynchronous reset with out nonzero, checked before any clock edge
    chk("pre_rst.out", out, PAT);
    #1 rst = 1;
    #1;
    model_reset();
    chk_rst_state("async_rst");
    @(posedge clk); #1;
    chk_rst_state("rst_held");
    rst = 0;
    // First edge after release is a normal IDLE write
    cyc(0, 1, 1, 4'h7, "post_rst");
    chk("post_rst.bit7", out, 16'h0080);

    // Stall at idx 7 for three cycles
    cyc(1, 0, 0, 4'h0, "stall_start");
    for (int k = 0; k < 7; k++) cyc(0, 1, pat[k], 4'h0, "stall_pre");
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, $urandom_range(1), 4'(k), "stall");
      chk("stall.idx", idx, 4'h7);
      chk("stall.busy", busy, 1'b1);
    end
    for (int k = 7; k < 16; k++) cyc(0, 1, pat[k], 4'h0, "stall_post");
    chk("stall.out", out, PAT);
    chk("stall.done", done, 1'b1);
    cyc(0, 0, 0, 4'h0, "stall_idle");

    // start during FILL at idx 5 is ignored
    cyc(1, 0, 0, 4'h0, "coll_start");
    for (int k = 0; k < 5; k++) cyc(0, 1, 1, 4'h0, "coll_pre");
    chk("coll.idx5", idx, 4'h5);
    cyc(1, 1, 0, 4'h0, "coll_restart");
    chk("coll.noclear", out, 16'h001f);
    chk("coll.idx6", idx, 4'h6);
    for (int k = 6; k < 16; k++) cyc(0, 1, 1, 4'h0, "coll_fill");
    cyc(0, 0, 0, 4'h0, "coll_done");
    // start beats a same-cycle direct write
    cyc(1, 1, 1, 4'h2, "start_wins");
    chk("start_wins.out", out, 16'h0000);
    chk("start_wins.busy", busy, 1'b1);

    // Reset mid-frame at idx 9: frame abandoned, no done pulse
    for (int k = 0; k < 9; k++) cyc(0, 1, 1, 4'h0, "abort_pre");
    chk("abort.idx9", idx, 4'h9);
    #1 rst = 1;
    #1;
    model_reset();
    chk_rst_state("abort_rst");
    @(posedge clk); #1;
    rst = 0;
    saw_done = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(0, 0, 0, 4'h0, "abort_after");
      if (done) saw_done = 1;
    end
    chk("abort.no_done", saw_done, 1'b0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(19) == 0, $urandom_range(9) < 7, $urandom_range(1),
          4'($urandom_range(15)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
